// File: rtl/gam_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gam_pkg
// Description : Shared types and helpers for the GAM engine blocks.
// Revision    : 1.0
// ============================================================================
package gam_pkg;

    localparam int PATTERN_W = 16;
    localparam int TH_W      = 5;
    localparam int M_W       = 8;
    localparam int DIST_W    = $clog2(PATTERN_W + 1);

    typedef logic [PATTERN_W-1:0] node_vector_T;

    typedef enum logic {
        LEARNING = 1'b0,
        RECALL   = 1'b1
    } LEARNING_RECALL_T;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        WAIT  = 2'd2
    } READY_WAIT_T;

    typedef struct packed {
        node_vector_T    W;
        logic [TH_W-1:0] Th;
        logic [M_W-1:0]  M;
    } node_T;

    function automatic logic [DIST_W-1:0] hamming_distance(input node_vector_T a,
                                                           input node_vector_T b);
        return DIST_W'($countones(a ^ b));
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_layer_if.sv
`default_nettype none
// ============================================================================
// Interface   : memory_layer_if
// Description : Pipe-side learning/recall bus of the GAM memory layer.
// Revision    : 1.0
// ============================================================================
interface memory_layer_if;
    import gam_pkg::*;

    node_vector_T     x;
    int               c;
    logic             learning_done;
    LEARNING_RECALL_T learning_recall;
    int               Tk;
    READY_WAIT_T      ready_wait;
    node_vector_T     recalling_pattern;
    int               class_name;

    modport master (
        output x, c, learning_done, learning_recall, Tk,
        input  ready_wait, recalling_pattern, class_name
    );

    modport slave (
        input  x, c, learning_done, learning_recall, Tk,
        output ready_wait, recalling_pattern, class_name
    );

endinterface
`default_nettype wire

// File: rtl/gam_recall.sv
`default_nettype none
// ============================================================================
// Module      : gam_recall
// Description : Nearest-node search over all classes with registered result.
// Revision    : 1.0
// ============================================================================
module gam_recall
    import gam_pkg::*;
#(
    parameter int NUM_CLASSES     = 8,
    parameter int NODES_PER_CLASS = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  node_T [NUM_CLASSES-1:0][NODES_PER_CLASS-1:0]      i_memory,
    input  node_vector_T                                      i_x,
    input  int                                                i_tk,
    input  LEARNING_RECALL_T                                  i_learning_recall,
    output node_vector_T                                      o_recalling_pattern,
    output int                                                o_class_name
);

    localparam int c_CLS_IW  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int c_NODE_IW = (NODES_PER_CLASS > 1) ? $clog2(NODES_PER_CLASS) : 1;

    logic              w_found;
    logic [DIST_W-1:0] w_best_d;
    node_vector_T      w_best_w;
    int                w_best_cls;
    logic              w_hit;
    logic              w_unused_th;
    node_vector_T      r_pattern;
    int                r_class;

    // Strict '<' while scanning ascending keeps the lowest class/node on ties.
    always_comb begin : p_search
        node_T           v_node;
        logic [DIST_W-1:0] v_d;
        logic [TH_W-1:0] v_th;
        v_node     = '0;
        v_d        = '0;
        v_th       = '0;
        w_found    = 1'b0;
        w_best_d   = '0;
        w_best_w   = '0;
        w_best_cls = 0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            for (int n = 0; n < NODES_PER_CLASS; n++) begin
                v_node = i_memory[c_CLS_IW'(k)][c_NODE_IW'(n)];
                v_d    = hamming_distance(i_x, v_node.W);
                v_th   = v_th ^ v_node.Th;
                if ((v_node.M != '0) && (!w_found || (v_d < w_best_d))) begin
                    w_found    = 1'b1;
                    w_best_d   = v_d;
                    w_best_w   = v_node.W;
                    w_best_cls = k + 1;
                end
            end
        end
        w_unused_th = ^v_th;
    end

    assign w_hit = w_found && (i_tk >= 0) && ($signed(32'(w_best_d)) <= i_tk);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= '0;
            r_class   <= 0;
        end else if (i_learning_recall == RECALL) begin
            if (w_hit) begin
                r_pattern <= w_best_w;
                r_class   <= w_best_cls;
            end else begin
                r_pattern <= i_x;
                r_class   <= 0;
            end
        end
    end

    assign o_recalling_pattern = r_pattern;
    assign o_class_name        = r_class;

endmodule
`default_nettype wire

// File: rtl/memory_layer.sv
`default_nettype none
// ============================================================================
// Module      : memory_layer
// Description : GAM per-class node storage, learning handshake FSM and recall.
// Revision    : 1.0
// ============================================================================
module memory_layer
    import gam_pkg::*;
#(
    parameter int NUM_CLASSES     = 8,
    parameter int NODES_PER_CLASS = 4,
    parameter int TH_INIT         = 2,
    parameter int M_MAX           = 255
) (
    input  logic          clk,
    input  logic          reset,
    memory_layer_if.slave bus
);

    localparam int c_CLS_IW  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int c_NODE_IW = (NODES_PER_CLASS > 1) ? $clog2(NODES_PER_CLASS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READY  = 2'd1,
        S_LATCH  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                                         r_state;
    state_t                                         w_next_state;
    node_T [NUM_CLASSES-1:0][NODES_PER_CLASS-1:0]   r_memory;
    node_vector_T                                   r_x;
    int                                             r_c;
    logic                                           r_done;

    node_T [NODES_PER_CLASS-1:0] w_nodes;
    logic                        w_valid;
    logic                        w_near_found;
    logic [c_NODE_IW-1:0]        w_near_idx;
    logic [DIST_W-1:0]           w_near_d;
    node_T                       w_near_node;
    logic                        w_empty_found;
    logic [c_NODE_IW-1:0]        w_empty_idx;
    logic                        w_wr_en;
    logic [c_CLS_IW-1:0]         w_wr_cls;
    logic [c_NODE_IW-1:0]        w_wr_idx;
    node_T                       w_wr_node;
    node_vector_T                w_recall_pattern;
    int                          w_recall_class;

    function automatic logic [M_W-1:0] sat_inc(input logic [M_W-1:0] m);
        return (m >= M_W'(M_MAX)) ? m : m + 1'b1;
    endfunction

    always_comb begin : p_fsm
        w_next_state   = r_state;
        bus.ready_wait = IDLE;
        case (r_state)
            S_IDLE: begin
                if ((bus.learning_recall == LEARNING) && !bus.learning_done)
                    w_next_state = S_READY;
            end
            S_READY: begin
                bus.ready_wait = READY;
                w_next_state   = S_LATCH;
            end
            S_LATCH: begin
                bus.ready_wait = WAIT;
                w_next_state   = S_UPDATE;
            end
            S_UPDATE: begin
                bus.ready_wait = WAIT;
                w_next_state   = (r_done || (bus.learning_recall == RECALL)) ? S_IDLE : S_READY;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Nearest node (ties to lowest index) and first empty slot of the latched class.
    always_comb begin : p_learn
        node_T             v_node;
        logic [DIST_W-1:0] v_d;
        v_node        = '0;
        v_d           = '0;
        w_valid       = (r_c >= 1) && (r_c <= NUM_CLASSES);
        w_nodes       = w_valid ? r_memory[c_CLS_IW'(r_c - 1)] : '0;
        w_near_found  = 1'b0;
        w_near_idx    = '0;
        w_near_d      = '0;
        w_near_node   = '0;
        w_empty_found = 1'b0;
        w_empty_idx   = '0;
        for (int n = 0; n < NODES_PER_CLASS; n++) begin
            v_node = w_nodes[c_NODE_IW'(n)];
            v_d    = hamming_distance(r_x, v_node.W);
            if (v_node.M != '0) begin
                if (!w_near_found || (v_d < w_near_d)) begin
                    w_near_found = 1'b1;
                    w_near_idx   = c_NODE_IW'(n);
                    w_near_d     = v_d;
                    w_near_node  = v_node;
                end
            end else if (!w_empty_found) begin
                w_empty_found = 1'b1;
                w_empty_idx   = c_NODE_IW'(n);
            end
        end

        w_wr_en   = 1'b0;
        w_wr_cls  = c_CLS_IW'(r_c - 1);
        w_wr_idx  = w_near_idx;
        w_wr_node = w_near_node;
        if ((r_state == S_UPDATE) && w_valid) begin
            w_wr_en = 1'b1;
            if (w_near_found && (TH_W'(w_near_d) <= w_near_node.Th)) begin
                w_wr_node.M = sat_inc(w_near_node.M);
            end else if (w_empty_found) begin
                w_wr_idx  = w_empty_idx;
                w_wr_node = '{W: r_x, Th: TH_W'(TH_INIT), M: M_W'(1)};
            end else begin
                // Class full: widen the nearest node to absorb this pattern.
                w_wr_node.Th = TH_W'(w_near_d);
                w_wr_node.M  = sat_inc(w_near_node.M);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_c      <= 0;
            r_done   <= 1'b0;
            r_memory <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_LATCH) begin
                r_x    <= bus.x;
                r_c    <= bus.c;
                r_done <= bus.learning_done;
            end
            if (w_wr_en)
                r_memory[w_wr_cls][w_wr_idx] <= w_wr_node;
        end
    end

    gam_recall #(
        .NUM_CLASSES     (NUM_CLASSES),
        .NODES_PER_CLASS (NODES_PER_CLASS)
    ) u_recall (
        .clk                 (clk),
        .reset               (reset),
        .i_memory            (r_memory),
        .i_x                 (bus.x),
        .i_tk                (bus.Tk),
        .i_learning_recall   (bus.learning_recall),
        .o_recalling_pattern (w_recall_pattern),
        .o_class_name        (w_recall_class)
    );

    assign bus.recalling_pattern = w_recall_pattern;
    assign bus.class_name        = w_recall_class;

endmodule
`default_nettype wire

// File: tb/tb_memory_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_layer
// Description : Directed scoreboard bench for the GAM memory layer.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_memory_layer;
    import gam_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    memory_layer_if bus_if();

    memory_layer #(
        .NUM_CLASSES     (8),
        .NODES_PER_CLASS (4),
        .TH_INIT         (2),
        .M_MAX           (255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] nd(input logic [15:0] w, input logic [4:0] th, input logic [7:0] m);
        return {35'd0, w, th, m};
    endfunction

    function automatic logic [63:0] mem(input int k, input int n);
        return {35'd0, dut.r_memory[k-1][n-1]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // One READY/WAIT transfer; returns at the negedge after the memory write.
    task automatic learn(input logic [15:0] vx, input int vc, input logic vdone, input READY_WAIT_T after);
        int guard = 0;
        while ((bus_if.ready_wait !== READY) && (guard < 20)) begin
            @(negedge clk);
            guard++;
        end
        if (bus_if.ready_wait !== READY)
            check("hs_ready_timeout", 64'(bus_if.ready_wait), 64'(READY));
        @(posedge clk);
        #1;
        bus_if.x             = vx;
        bus_if.c             = vc;
        bus_if.learning_done = vdone;
        @(negedge clk);
        check("hs_wait0", 64'(bus_if.ready_wait), 64'(WAIT));
        @(negedge clk);
        check("hs_wait1", 64'(bus_if.ready_wait), 64'(WAIT));
        @(negedge clk);
        check("hs_after", 64'(bus_if.ready_wait), 64'(after));
    endtask

    task automatic recall(input logic [15:0] vx, input int vtk, input logic [15:0] epat, input int ecls);
        bus_if.x  = vx;
        bus_if.Tk = vtk;
        sb_push("rc_pat", {48'd0, epat});
        sb_push("rc_cls", 64'(ecls));
        @(negedge clk);
        sb_pop({48'd0, bus_if.recalling_pattern});
        sb_pop(64'(bus_if.class_name));
    endtask

    initial begin
        bus_if.x               = '0;
        bus_if.c               = 0;
        bus_if.learning_done   = 1'b0;
        bus_if.learning_recall = LEARNING;
        bus_if.Tk              = 0;

        repeat (3) @(negedge clk);
        check("rst_rw",  64'(bus_if.ready_wait), 64'(IDLE));
        check("rst_pat", {48'd0, bus_if.recalling_pattern}, 64'd0);
        check("rst_cls", 64'(bus_if.class_name), 64'd0);
        check("rst_mem", mem(1, 1), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", 64'(bus_if.ready_wait), 64'(READY));

        sb_push("c1n1_new", nd(16'hFFFF, 5'd2, 8'd1));
        learn(16'hFFFF, 1, 1'b0, READY);
        sb_pop(mem(1, 1));

        sb_push("c1n1_inc", nd(16'hFFFF, 5'd2, 8'd2));
        sb_push("c1n2_empty", 64'd0);
        learn(16'hFFFE, 1, 1'b0, READY);
        sb_pop(mem(1, 1));
        sb_pop(mem(1, 2));

        sb_push("c1n2_new", nd(16'h0000, 5'd2, 8'd1));
        learn(16'h0000, 1, 1'b0, READY);
        sb_pop(mem(1, 2));
        sb_push("c1n3_new", nd(16'h00FF, 5'd2, 8'd1));
        learn(16'h00FF, 1, 1'b0, READY);
        sb_pop(mem(1, 3));
        sb_push("c1n4_new", nd(16'h0F0F, 5'd2, 8'd1));
        learn(16'h0F0F, 1, 1'b0, READY);
        sb_pop(mem(1, 4));

        sb_push("c1n2_full", nd(16'h0000, 5'd4, 8'd2));
        sb_push("c1n3_keep", nd(16'h00FF, 5'd2, 8'd1));
        learn(16'h000F, 1, 1'b0, READY);
        sb_pop(mem(1, 2));
        sb_pop(mem(1, 3));

        sb_push("c0_c1n1", nd(16'hFFFF, 5'd2, 8'd2));
        sb_push("c0_c8n1", 64'd0);
        learn(16'h1234, 0, 1'b0, READY);
        sb_pop(mem(1, 1));
        sb_pop(mem(8, 1));

        sb_push("c9_c8n1", 64'd0);
        sb_push("c9_c1n2", nd(16'h0000, 5'd4, 8'd2));
        learn(16'h1234, 9, 1'b0, READY);
        sb_pop(mem(8, 1));
        sb_pop(mem(1, 2));

        sb_push("c5n1_last", nd(16'hAAAA, 5'd2, 8'd1));
        learn(16'hAAAA, 5, 1'b1, IDLE);
        sb_pop(mem(5, 1));
        @(negedge clk);
        check("done_idle", 64'(bus_if.ready_wait), 64'(IDLE));

        bus_if.learning_recall = RECALL;
        recall(16'hFFFC, 15, 16'hFFFF, 1);
        recall(16'h5555, 0,  16'h5555, 0);
        recall(16'hFFFF, -1, 16'hFFFF, 0);
        recall(16'h000F, 3,  16'h000F, 0);
        recall(16'h000F, 4,  16'h0000, 1);
        recall(16'hAAAA, 0,  16'hAAAA, 5);

        bus_if.learning_recall = LEARNING;
        bus_if.x               = 16'h1111;
        @(negedge clk);
        check("hold_pat", {48'd0, bus_if.recalling_pattern}, {48'd0, 16'hAAAA});
        check("hold_cls", 64'(bus_if.class_name), 64'd5);

        // Abort an item in flight with reset.
        bus_if.learning_done = 1'b0;
        @(negedge clk);
        check("re_ready", 64'(bus_if.ready_wait), 64'(READY));
        @(posedge clk);
        #1;
        bus_if.x = 16'hFFFF;
        bus_if.c = 2;
        @(negedge clk);
        check("mid_wait", 64'(bus_if.ready_wait), 64'(WAIT));
        reset = 1'b0;
        #1;
        check("mid_rw",   64'(bus_if.ready_wait), 64'(IDLE));
        check("mid_pat",  {48'd0, bus_if.recalling_pattern}, 64'd0);
        check("mid_cls",  64'(bus_if.class_name), 64'd0);
        check("mid_c1n1", mem(1, 1), 64'd0);
        check("mid_c5n1", mem(5, 1), 64'd0);
        bus_if.c             = 0;
        bus_if.learning_done = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_c2n1", mem(2, 1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_layer.md
# memory_layer

GAM (growing associative memory) storage and recall block. Learns binary patterns into per-class node sets during a learning phase, using a READY/WAIT handshake with the input pipe. During the recall phase it returns the nearest stored pattern and its class for each probe vector. Sits between the input control pipe and the output writer of the GAM engine.

## Interface
- NUM_CLASSES, 8: classes indexed 1..NUM_CLASSES; class 0 is invalid.
- NODES_PER_CLASS, 4: node slots per class, indexed 1..NODES_PER_CLASS.
- TH_INIT, 2: threshold given to a newly created node.
- M_MAX, 255: saturation value of a node's match counter.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low; clears all state.
- x  input  node_vector_T (PATTERN_W=16)  pattern to learn or probe.
- c  input  int (32)  class of pattern during learning.
- learning_done  input  1  high while the final learning item is presented, and afterwards.
- learning_recall  input  LEARNING_RECALL_T  phase select, LEARNING or RECALL.
- Tk  input  int (32)  maximum Hamming distance accepted in recall.
- ready_wait  output  READY_WAIT_T  IDLE, READY or WAIT.
- recalling_pattern  output  node_vector_T  recalled pattern.
- class_name  output  int (32)  recalled class; 0 means no match.

## Operation
- Storage is named memory, organised as classes[1..NUM_CLASSES].node[1..NODES_PER_CLASS], each node holding {W, Th, M}.
  - W: node_vector_T.
  - Th: 5-bit threshold.
  - M: 8-bit match counter.
  - A node is empty when M==0.
- Learning FSM, internal states S_IDLE, S_READY, S_LATCH, S_UPDATE:
  - S_IDLE drives ready_wait=IDLE. S_READY drives READY. S_LATCH and S_UPDATE drive WAIT.
  - S_IDLE → S_READY when learning_recall==LEARNING and learning_done==0.
  - S_READY → S_LATCH on every posedge. Each posedge spent in S_READY is one transfer; the pipe drives x and c just after that edge.
  - S_LATCH: register x, c and learning_done. Compute the Hamming distance d from x to every non-empty node of class c. Go to S_UPDATE.
  - S_UPDATE: write memory. Go to S_IDLE if the latched learning_done==1 or learning_recall==RECALL; otherwise go to S_READY.
- Learning rule, applied for class c:
  - If c<1 or c>NUM_CLASSES: no write.
  - Find the nearest non-empty node n, breaking ties on the lowest index.
  - If n exists and d≤n.Th: n.M increments, saturating at M_MAX.
  - Else, if an empty slot exists: the lowest-index empty slot gets W=x, Th=TH_INIT, M=1.
  - Else (class full): n.Th=d, n.M increments, saturating.
- Recall, active while learning_recall==RECALL, evaluated every posedge:
  - Scan all non-empty nodes of all classes and take the minimum d. Ties go to the lowest class, then the lowest node.
  - If a node is found and d≤Tk: recalling_pattern←W, class_name←its class.
  - Otherwise recalling_pattern←x, class_name←0.
  - A negative Tk is treated as no match.
- While in LEARNING, recalling_pattern and class_name hold their values.

## Timing
- Reset asserted: ready_wait=IDLE, recalling_pattern=0, class_name=0, every node M=0, Th=0, W=0, FSM in S_IDLE.
- Reset mid-operation: all state clears immediately and the in-flight item is lost.
- First posedge after reset release, with LEARNING and learning_done=0: ready_wait=READY.
- Handshake, with T0 the transfer edge:
  - ready_wait=WAIT after T0.
  - Inputs are sampled at T0+1.
  - Memory is written and ready_wait returns to READY (or IDLE) at T0+2.
  - Throughput: one item per 3 cycles.
- If learning_recall switches to RECALL in S_LATCH or S_UPDATE, the current item completes, then the FSM goes to S_IDLE.
- Recall latency: x driven before posedge P gives outputs valid after P.
- Same-cycle learning write and recall read do not occur, because the phases are exclusive.

## Structure
- Shared package gam_pkg holds:
  - PATTERN_W=16.
  - node_vector_T (logic [PATTERN_W-1:0]).
  - LEARNING_RECALL_T {LEARNING, RECALL}.
  - READY_WAIT_T {IDLE, READY, WAIT}.
  - node_T struct {W, Th, M}.
  - A hamming_distance function.
- One sub-module, gam_recall: the nearest-node search and output registers. It reads the memory array through a packed port and receives x, Tk and learning_recall.

## Test plan
- Reset held low → ready_wait=IDLE, recalling_pattern=16'h0000, class_name=0. Release reset → READY on the next posedge.
- Learn x=16'hFFFF, c=1 → class1.node1 = {FFFF, Th 2, M 1}. Sequence is WAIT, WAIT, then READY.
- Learn x=16'hFFFE, c=1 (d=1) → node1 M=2, node2 stays empty.
- Learn x=16'h0000 in c=1, then 16'h00FF, then 16'h0F0F → node2..node4 filled. Then learn x=16'h000F → node2 (d=4) gets Th=4, M=2.
- Learn x=16'h1234 with c=0 → memory unchanged, handshake still completes.
- Last item x=16'hAAAA, c=5 with learning_done=1 → class5.node1 = {AAAA, 2, 1} and ready_wait=IDLE.
- Recall, following the final-item scenario:
  - x=16'hFFFC, Tk=15 → recalling_pattern=16'hFFFF, class_name=1.
  - x=16'h5555, Tk=0 → recalling_pattern=16'h5555, class_name=0.
